// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory bus arbiter: FSM state encoding,
//   byte-strobe width helper and the default bus timeout.
//   Optional build macro used by the arbiter: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    // Arbiter state encodings
    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_I_ADDR = 3'd1;
    localparam logic [2:0] ENC_I_WAIT = 3'd2;
    localparam logic [2:0] ENC_D_ADDR = 3'd3;
    localparam logic [2:0] ENC_D_WAIT = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ENC_IDLE,
        I_ADDR = ENC_I_ADDR,
        I_WAIT = ENC_I_WAIT,
        D_ADDR = ENC_D_ADDR,
        D_WAIT = ENC_D_WAIT
    } arb_state_t;

    // Cycles spent in a WAIT state before giving up (timeout build only)
    localparam int ARB_TIMEOUT_DEF = 255;

    // One strobe bit per data byte
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares a single SRAM-like bus (req / addr_ok / data_ok) between the
//   instruction-fetch port and the MEM-stage data port of a 5-stage core.
//   One transaction is outstanding at a time; a pending data access is
//   always issued before a pending fetch. Returned words are held until
//   the pipeline advances, so each result is consumed exactly once.
//
//   Build macro: MEM_ARB_TIMEOUT_EN
//     defined   - a wait counter aborts a transaction after TIMEOUT cycles
//                 without bus_data_ok, sets sticky bus_err and completes the
//                 requester with a zero word.
//     undefined - WAIT states wait indefinitely; bus_err is tied low.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   inst_req/inst_addr           fetch request (level) and address
//   inst_rdata                   held instruction word
//   data_req/data_wen/data_addr  data request, byte strobes (0 = read), address
//   data_wdata / data_rdata      store data / held load data
//   advance                      pipeline advances this cycle
//   mem_stall                    a fetch or data access is still outstanding
//   bus_req/bus_wr/bus_wstrb     bus request, write flag, byte strobes
//   bus_addr/bus_wdata           bus address and write data
//   bus_addr_ok/bus_data_ok      address accepted / transaction complete
//   bus_rdata                    bus read data
//   bus_err                      sticky timeout flag
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,
    input  logic                  advance,
    output logic                  mem_stall,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  bus_err
);

    localparam int STRB_W = strb_width(DATA_W);

    arb_state_t state;
    logic       inst_done;
    logic       data_done;
    logic       inst_pend;
    logic       data_pend;
    logic       timeout_hit;

    assign inst_pend = inst_req & ~inst_done;
    assign data_pend = data_req & ~data_done;
    assign mem_stall = inst_pend | data_pend;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait     = (state == I_WAIT) || (state == D_WAIT);
    assign timeout_hit = in_wait & ~bus_data_ok & (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Counter restarts on every WAIT entry; bus_err stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (in_wait && !bus_data_ok && !timeout_hit)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
            if (timeout_hit)
                bus_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign bus_err        = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_wstrb  <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
        end else begin
            // Clear on advance first; a completion later in this block
            // overrides it, so a freshly returned word is never lost.
            if (advance) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (data_pend) begin
                        state     <= D_ADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= |data_wen;
                        bus_wstrb <= data_wen;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                    end else if (inst_pend) begin
                        state     <= I_ADDR;
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_wstrb <= '0;
                        bus_addr  <= inst_addr;
                        bus_wdata <= '0;
                    end
                end

                // A requester that dropped req (flush) gets nothing back:
                // the bus transaction still completes but done stays clear.
                I_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        if (bus_data_ok) begin
                            state <= IDLE;
                            if (inst_req) begin
                                inst_rdata <= bus_rdata;
                                inst_done  <= 1'b1;
                            end
                        end else begin
                            state <= I_WAIT;
                        end
                    end
                end

                I_WAIT: begin
                    if (bus_data_ok || timeout_hit) begin
                        state <= IDLE;
                        if (inst_req) begin
                            inst_rdata <= bus_data_ok ? bus_rdata : '0;
                            inst_done  <= 1'b1;
                        end
                    end
                end

                D_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        if (bus_data_ok) begin
                            state <= IDLE;
                            if (data_req) begin
                                if (!bus_wr)
                                    data_rdata <= bus_rdata;
                                data_done <= 1'b1;
                            end
                        end else begin
                            state <= D_WAIT;
                        end
                    end
                end

                D_WAIT: begin
                    if (bus_data_ok || timeout_hit) begin
                        state <= IDLE;
                        if (data_req) begin
                            if (!bus_wr)
                                data_rdata <= bus_data_ok ? bus_rdata : '0;
                            data_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Strobe port width is derived from DATA_W; keep the package helper honest.
    if (STRB_W != DATA_W / 8) begin : g_bad_strb
        $error("strobe width mismatch");
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter. A bus-bridge model answers
//   requests with programmable addr_ok / data_ok delays; every expected bus
//   transaction is queued when the stimulus is driven and checked when the
//   arbiter's request is accepted.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic [STRB_W-1:0] data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              advance;
    logic              mem_stall;
    logic              bus_req;
    logic              bus_wr;
    logic [STRB_W-1:0] bus_wstrb;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    mem_bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .data_req   (data_req),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .advance    (advance),
        .mem_stall  (mem_stall),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_wstrb  (bus_wstrb),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Bridge model knobs and observation counters
    int addr_dly = 0;
    int data_dly = 1;
    bit no_data  = 1'b0;
    int phase    = 0;
    int n_txn    = 0;
    int n_dok    = 0;

    function automatic logic [DATA_W-1:0] model_rdata(input logic [ADDR_W-1:0] a);
        if (a == 32'hBFC0_0000)
            return 32'h2408_0001;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic w,
                            input logic [STRB_W-1:0] s, input logic [DATA_W-1:0] d);
        txn_t t;
        t.addr  = a;
        t.wr    = w;
        t.strb  = s;
        t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic wait_stall_low(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (!mem_stall)
                ok = 1'b1;
        end
    endtask

    task automatic retire();
        advance  = 1'b1;
        inst_req = 1'b0;
        data_req = 1'b0;
        data_wen = '0;
        @(negedge clk);
        advance  = 1'b0;
        @(negedge clk);
    endtask

    // Bus-bridge model: answers one request at a time and checks each
    // accepted request against the head of the expectation queue.
    initial begin
        logic [ADDR_W-1:0] cur_addr;
        logic              cur_wr;
        int                acnt;
        int                dcnt;
        txn_t              e;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
        cur_addr    = '0;
        cur_wr      = 1'b0;
        acnt        = 0;
        dcnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (rst) begin
                phase = 0;
                acnt  = 0;
            end else if (phase == 0) begin
                if (bus_req) begin
                    if (acnt == 0) begin
                        cur_addr = bus_addr;
                    end else begin
                        n_vec++;
                        if (bus_addr !== cur_addr) begin
                            n_err++;
                            $display("FAIL addr_stable: bus_addr=%h, expected %h", bus_addr, cur_addr);
                        end
                    end
                    if (acnt == addr_dly) begin
                        bus_addr_ok = 1'b1;
                        n_txn++;
                        acnt   = 0;
                        cur_wr = bus_wr;
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_txn: addr=%h wr=%b, expected no transaction", bus_addr, bus_wr);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus_addr !== e.addr || bus_wr !== e.wr || bus_wstrb !== e.strb ||
                                (e.wr && bus_wdata !== e.wdata)) begin
                                n_err++;
                                $display("FAIL bus_txn: got addr=%h wr=%b strb=%b wdata=%h, expected addr=%h wr=%b strb=%b wdata=%h",
                                         bus_addr, bus_wr, bus_wstrb, bus_wdata, e.addr, e.wr, e.strb, e.wdata);
                            end
                        end
                        if (!no_data && data_dly == 0) begin
                            bus_data_ok = 1'b1;
                            n_dok++;
                            bus_rdata = cur_wr ? 32'hDEAD_DEAD : model_rdata(cur_addr);
                        end else begin
                            phase = 1;
                            dcnt  = 0;
                        end
                    end else begin
                        acnt++;
                    end
                end
            end else begin
                n_vec++;
                if (bus_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL req_in_wait: bus_req=%b, expected 0", bus_req);
                end
                if (!no_data) begin
                    dcnt++;
                    if (dcnt >= data_dly) begin
                        bus_data_ok = 1'b1;
                        n_dok++;
                        bus_rdata = cur_wr ? 32'hDEAD_DEAD : model_rdata(cur_addr);
                        phase = 0;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (bus_req !== 1'b0 || bus_wr !== 1'b0 || bus_wstrb !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: req=%b wr=%b strb=%b, expected 0 0 0", bus_req, bus_wr, bus_wstrb);
        end
        n_vec++;
        if (bus_addr !== '0 || bus_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_bus: addr=%h wdata=%h, expected 0", bus_addr, bus_wdata);
        end
        n_vec++;
        if (inst_rdata !== '0 || data_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_rdata: inst=%h data=%h, expected 0", inst_rdata, data_rdata);
        end
        n_vec++;
        if (mem_stall !== 1'b0 || bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: stall=%b err=%b, expected 0 0", mem_stall, bus_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single fetch, then the pipeline holds for 5 cycles before advancing.
    task automatic test_fetch_hold();
        bit ok;
        int t0;
        addr_dly = 0;
        data_dly = 1;
        t0 = n_txn;
        push_exp(32'hBFC0_0000, 1'b0, '0, '0);
        inst_addr = 32'hBFC0_0000;
        inst_req  = 1'b1;
        wait_stall_low(20, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL fetch_done: mem_stall=%b, expected 0 within 20 cycles", mem_stall);
        end
        n_vec++;
        if (inst_rdata !== 32'h2408_0001) begin
            n_err++;
            $display("FAIL fetch_rdata: got %h, expected %h", inst_rdata, 32'h2408_0001);
        end
        n_vec++;
        if (n_txn - t0 !== 1) begin
            n_err++;
            $display("FAIL fetch_pulses: got %0d transactions, expected 1", n_txn - t0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (mem_stall !== 1'b0 || n_txn - t0 !== 1 || inst_rdata !== 32'h2408_0001) begin
                n_err++;
                $display("FAIL hold_cycle%0d: stall=%b txns=%0d rdata=%h, expected 0 1 %h",
                         i, mem_stall, n_txn - t0, inst_rdata, 32'h2408_0001);
            end
        end
        push_exp(32'hBFC0_0004, 1'b0, '0, '0);
        inst_addr = 32'hBFC0_0004;
        advance   = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        wait_stall_low(20, ok);
        n_vec++;
        if (!ok || inst_rdata !== model_rdata(32'hBFC0_0004) || n_txn - t0 !== 2) begin
            n_err++;
            $display("FAIL hold_next: ok=%b rdata=%h txns=%0d, expected 1 %h 2",
                     ok, inst_rdata, model_rdata(32'hBFC0_0004), n_txn - t0);
        end
        retire();
    endtask

    // addr_ok and data_ok in the same cycle: stall falls 2 cycles after req.
    task automatic test_latency();
        addr_dly = 0;
        data_dly = 0;
        push_exp(32'hBFC0_0100, 1'b0, '0, '0);
        inst_addr = 32'hBFC0_0100;
        inst_req  = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mem_stall !== 1'b1) begin
            n_err++;
            $display("FAIL latency_c1: mem_stall=%b, expected 1", mem_stall);
        end
        @(negedge clk);
        n_vec++;
        if (mem_stall !== 1'b0 || inst_rdata !== model_rdata(32'hBFC0_0100)) begin
            n_err++;
            $display("FAIL latency_c2: stall=%b rdata=%h, expected 0 %h",
                     mem_stall, inst_rdata, model_rdata(32'hBFC0_0100));
        end
        retire();
    endtask

    // Fetch and load together: load goes first, stall holds until both finish.
    task automatic test_priority();
        bit ok;
        int t0;
        int d0;
        addr_dly = 0;
        data_dly = 1;
        t0 = n_txn;
        d0 = n_dok;
        push_exp(32'h8000_0010, 1'b0, '0, '0);
        push_exp(32'hBFC0_0200, 1'b0, '0, '0);
        data_addr  = 32'h8000_0010;
        data_wen   = '0;
        data_wdata = '0;
        inst_addr  = 32'hBFC0_0200;
        data_req   = 1'b1;
        inst_req   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (n_dok > d0)
                ok = 1'b1;
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (!ok || mem_stall !== 1'b1 || data_rdata !== model_rdata(32'h8000_0010)) begin
            n_err++;
            $display("FAIL prio_mid: data_ok_seen=%b stall=%b data_rdata=%h, expected 1 1 %h",
                     ok, mem_stall, data_rdata, model_rdata(32'h8000_0010));
        end
        wait_stall_low(20, ok);
        n_vec++;
        if (!ok || inst_rdata !== model_rdata(32'hBFC0_0200) || n_txn - t0 !== 2) begin
            n_err++;
            $display("FAIL prio_end: ok=%b inst_rdata=%h txns=%0d, expected 1 %h 2",
                     ok, inst_rdata, model_rdata(32'hBFC0_0200), n_txn - t0);
        end
        retire();
    endtask

    // Partial store: strobes and data reach the bus, load data untouched.
    task automatic test_store();
        bit                ok;
        logic [DATA_W-1:0] prev;
        addr_dly = 0;
        data_dly = 1;
        prev = data_rdata;
        push_exp(32'h8000_0004, 1'b1, 4'b0011, 32'h0000_BEEF);
        data_addr  = 32'h8000_0004;
        data_wen   = 4'b0011;
        data_wdata = 32'h0000_BEEF;
        data_req   = 1'b1;
        wait_stall_low(20, ok);
        n_vec++;
        if (!ok || data_rdata !== prev) begin
            n_err++;
            $display("FAIL store: ok=%b data_rdata=%h, expected 1 %h", ok, data_rdata, prev);
        end
        retire();
    endtask

    // Slow address acceptance: each request held 4 cycles, no overlap.
    task automatic test_back_to_back();
        bit ok;
        int req_cyc;
        addr_dly = 3;
        data_dly = 2;
        push_exp(32'h8000_0020, 1'b0, '0, '0);
        push_exp(32'hBFC0_0300, 1'b0, '0, '0);
        data_addr  = 32'h8000_0020;
        data_wen   = '0;
        data_wdata = '0;
        inst_addr  = 32'hBFC0_0300;
        data_req   = 1'b1;
        inst_req   = 1'b1;
        req_cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bus_req)
                req_cyc++;
            if (!mem_stall)
                ok = 1'b1;
        end
        n_vec++;
        if (!ok || req_cyc !== 8) begin
            n_err++;
            $display("FAIL b2b_req: ok=%b req_cycles=%0d, expected 1 8", ok, req_cyc);
        end
        n_vec++;
        if (data_rdata !== model_rdata(32'h8000_0020) || inst_rdata !== model_rdata(32'hBFC0_0300)) begin
            n_err++;
            $display("FAIL b2b_rdata: data=%h inst=%h, expected %h %h", data_rdata, inst_rdata,
                     model_rdata(32'h8000_0020), model_rdata(32'hBFC0_0300));
        end
        retire();
    endtask

    // Load flushed while in flight: result discarded, re-request reissues.
    task automatic test_flush();
        bit                ok;
        int                t0;
        int                d0;
        logic [DATA_W-1:0] prev;
        addr_dly = 0;
        data_dly = 3;
        prev = data_rdata;
        t0 = n_txn;
        push_exp(32'h8000_0030, 1'b0, '0, '0);
        data_addr = 32'h8000_0030;
        data_wen  = '0;
        data_req  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (n_txn > t0)
                ok = 1'b1;
        end
        data_req = 1'b0;
        d0 = n_dok;
        for (int i = 0; i < 20 && n_dok == d0; i++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        n_vec++;
        if (!ok || data_rdata !== prev || mem_stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_discard: accepted=%b data_rdata=%h stall=%b, expected 1 %h 0",
                     ok, data_rdata, mem_stall, prev);
        end
        push_exp(32'h8000_0030, 1'b0, '0, '0);
        data_req = 1'b1;
        wait_stall_low(30, ok);
        n_vec++;
        if (!ok || n_txn - t0 !== 2 || data_rdata !== model_rdata(32'h8000_0030)) begin
            n_err++;
            $display("FAIL flush_reissue: ok=%b txns=%0d data_rdata=%h, expected 1 2 %h",
                     ok, n_txn - t0, data_rdata, model_rdata(32'h8000_0030));
        end
        retire();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        addr_dly = 0;
        no_data  = 1'b1;
        push_exp(32'h8000_0050, 1'b0, '0, '0);
        data_addr = 32'h8000_0050;
        data_wen  = '0;
        data_req  = 1'b1;
        wait_stall_low(30, ok);
        n_vec++;
        if (!ok || bus_err !== 1'b1 || data_rdata !== '0) begin
            n_err++;
            $display("FAIL timeout: ok=%b bus_err=%b data_rdata=%h, expected 1 1 0", ok, bus_err, data_rdata);
        end
        retire();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: bus_err=%b, expected 0", bus_err);
        end
    endtask
`endif

    // Reset while waiting for data_ok: everything returns to zero at once.
    task automatic test_reset_mid();
        bit ok;
        addr_dly = 0;
        no_data  = 1'b1;
        push_exp(32'h8000_0040, 1'b0, '0, '0);
        data_addr = 32'h8000_0040;
        data_wen  = '0;
        data_req  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (phase == 1)
                ok = 1'b1;
        end
        @(negedge clk);
        rst      = 1'b1;
        data_req = 1'b0;
        #1;
        n_vec++;
        if (!ok || bus_req !== 1'b0 || bus_wr !== 1'b0 || bus_addr !== '0 || bus_wdata !== '0) begin
            n_err++;
            $display("FAIL rst_mid_bus: in_wait=%b req=%b wr=%b addr=%h wdata=%h, expected 1 0 0 0 0",
                     ok, bus_req, bus_wr, bus_addr, bus_wdata);
        end
        n_vec++;
        if (data_rdata !== '0 || inst_rdata !== '0 || mem_stall !== 1'b0 || bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_out: data=%h inst=%h stall=%b err=%b, expected 0 0 0 0",
                     data_rdata, inst_rdata, mem_stall, bus_err);
        end
        @(negedge clk);
        rst     = 1'b0;
        no_data = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_wen   = '0;
        data_addr  = '0;
        data_wdata = '0;
        advance    = 1'b0;
        test_reset();
        test_fetch_hold();
        test_latency();
        test_priority();
        test_store();
        test_back_to_back();
        test_flush();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL leftover_txns: %0d expected transactions never issued, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
